// File: rtl/ray_sched_pkg.sv
// Types and constants shared by the column scheduler, the ray setup unit and the DDA stage.
package ray_sched_pkg;

    localparam int SCREEN_WIDTH = 320;
    localparam int HC_WIDTH     = 9;
    localparam int CYC_WIDTH    = 24;

    // Q8.8 fixed point, signed for direction/plane vectors
    typedef logic signed [15:0] q8_8_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    typedef struct packed {
        q8_8_t pos_x;
        q8_8_t pos_y;
        q8_8_t dir_x;
        q8_8_t dir_y;
        q8_8_t plane_x;
        q8_8_t plane_y;
    } pose_t;

endpackage

// File: rtl/ray_column_scheduler_pose_latch.sv
// Six-word pose snapshot register; loads on load_i, otherwise holds its value for the whole frame.
module pose_latch
    import ray_sched_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  pose_t pose_i,
    output pose_t pose_o
);

    pose_t pose_q;
    pose_t pose_d;

    always_comb begin
        pose_d = pose_q;
        if (load_i) begin
            pose_d = pose_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pose_q <= '0;
        end else begin
            pose_q <= pose_d;
        end
    end

    assign pose_o = pose_q;

endmodule

// File: rtl/ray_column_scheduler.sv
// Frame sequencer: snapshots the pose, walks hcount across the screen one accepted ray result at a time,
// discards the stale in-flight result after frame start, and reports done/cycle count/overrun.
module ray_column_scheduler #(
    parameter int SCREEN_WIDTH = 320,
    parameter int HC_WIDTH     = 9,
    parameter int CYC_WIDTH    = 24
) (
    input  logic                 pixel_clk_in,
    input  logic                 rst_in,
    input  logic                 frame_start_in,
    input  logic [15:0]          posX_in,
    input  logic [15:0]          posY_in,
    input  logic [15:0]          dirX_in,
    input  logic [15:0]          dirY_in,
    input  logic [15:0]          planeX_in,
    input  logic [15:0]          planeY_in,
    output logic [15:0]          posX_out,
    output logic [15:0]          posY_out,
    output logic [15:0]          dirX_out,
    output logic [15:0]          dirY_out,
    output logic [15:0]          planeX_out,
    output logic [15:0]          planeY_out,
    output logic [HC_WIDTH-1:0]  hcount_out,
    input  logic                 ray_valid_in,
    output logic                 ray_ready_out,
    output logic                 dda_valid_out,
    input  logic                 dda_ready_in,
    output logic [HC_WIDTH-1:0]  col_tag_out,
    output logic                 frame_busy_out,
    output logic                 frame_done_out,
    output logic [CYC_WIDTH-1:0] frame_cycles_out,
    output logic                 overrun_out
);

    import ray_sched_pkg::*;

    localparam logic [HC_WIDTH-1:0]  LAST_COL = HC_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [CYC_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CYC_WIDTH-1:0] CNT_ONE  = CYC_WIDTH'(1);

    sched_state_t         state_q, state_d;
    logic [HC_WIDTH-1:0]  hcount_q, hcount_d;
    logic [CYC_WIDTH-1:0] cnt_q, cnt_d;
    logic [CYC_WIDTH-1:0] cycles_q, cycles_d;
    logic                 overrun_q, overrun_d;

    logic  pose_load;
    logic  busy;
    logic  xfer;
    logic  ray_ready_c;
    logic  dda_valid_c;
    logic  done_c;
    pose_t pose_in;
    pose_t pose_snap;

    assign pose_in = {posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in};

    pose_latch u_pose_latch (
        .clk_i  (pixel_clk_in),
        .rst_i  (rst_in),
        .load_i (pose_load),
        .pose_i (pose_in),
        .pose_o (pose_snap)
    );

    assign busy = (state_q == FLUSH) || (state_q == RUN);
    assign xfer = (state_q == RUN) && ray_valid_in && dda_ready_in;

    always_comb begin
        state_d     = state_q;
        hcount_d    = hcount_q;
        cnt_d       = cnt_q;
        cycles_d    = cycles_q;
        overrun_d   = overrun_q;
        pose_load   = 1'b0;
        ray_ready_c = 1'b1;
        dda_valid_c = 1'b0;
        done_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_start_in) begin
                    pose_load = 1'b1;
                    hcount_d  = '0;
                    cnt_d     = CNT_ONE;
                    state_d   = FLUSH;
                end
            end
            FLUSH: begin
                // The first result after the snapshot was set up from the old pose; drop it.
                if (ray_valid_in) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                dda_valid_c = ray_valid_in;
                ray_ready_c = dda_ready_in;
                if (xfer) begin
                    if (hcount_q == LAST_COL) begin
                        state_d = DONE;
                    end else begin
                        hcount_d = hcount_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done_c   = 1'b1;
                cycles_d = cnt_q;
                state_d  = IDLE;
                if (frame_start_in) begin
                    pose_load = 1'b1;
                    hcount_d  = '0;
                    cnt_d     = CNT_ONE;
                    state_d   = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (busy) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (frame_start_in) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            hcount_q  <= '0;
            cnt_q     <= '0;
            cycles_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcount_q  <= hcount_d;
            cnt_q     <= cnt_d;
            cycles_q  <= cycles_d;
            overrun_q <= overrun_d;
        end
    end

    // Ready is combinational from state, so it must be forced low while reset is held.
    assign ray_ready_out    = ray_ready_c && !rst_in;
    assign dda_valid_out    = dda_valid_c;
    assign hcount_out       = hcount_q;
    assign col_tag_out      = hcount_q;
    assign frame_busy_out   = busy;
    assign frame_done_out   = done_c;
    assign frame_cycles_out = cycles_q;
    assign overrun_out      = overrun_q;

    assign posX_out   = pose_snap.pos_x;
    assign posY_out   = pose_snap.pos_y;
    assign dirX_out   = pose_snap.dir_x;
    assign dirY_out   = pose_snap.dir_y;
    assign planeX_out = pose_snap.plane_x;
    assign planeY_out = pose_snap.plane_y;

endmodule
